rename_dispatch_ckpt: RTL and testbench
=======================================

Name: rename_dispatch_ckpt

Overview:
Parametrised N-wide rename/dispatch stage with internal checkpoint storage. Renames up to N head-aligned instructions per cycle through a register map table and resolves intra-group dependences. Allocates branch checkpoints (map snapshot plus branch mask) locally, and restores or releases them on branch resolution. Sits between the decoder/instruction buffer and the ROB/RS/free list; it replaces external branch-stack snapshotting of the map.

Parameters:
N, 2, dispatch width (lanes)
ARCH_REGS, 32, architectural registers; x0 never renamed
PHYS_REGS, 64, physical registers
NUM_CKPT, 4, checkpoint slots (branch-mask width)
CNT_W, $clog2(N+1), width of count signals
AREG_W / PREG_W / CKPT_W, $clog2 of ARCH_REGS / PHYS_REGS / NUM_CKPT

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high
in_count  in  CNT_W  valid instructions, head-aligned, lanes 0..in_count-1
in_has_dest  in  N  lane writes rd
in_is_branch  in  N  lane needs a checkpoint
in_rs1_used / in_rs2_used  in  N  source used
in_rs1 / in_rs2 / in_rd  in  N*AREG_W  architectural indices
rob_spots / rs_spots / free_count  in  CNT_W  capacity, each saturated at N
free_regs  in  N*PREG_W  lane i consumes free_regs[i] when it has a dest
complete_list  in  PHYS_REGS  registered ready bits
cdb_valid  in  N  completing-tag valid
cdb_tag  in  N*PREG_W  completing tags
br_valid  in  1  branch resolved this cycle
br_id  in  CKPT_W  checkpoint of resolving branch
br_mispredict  in  1  restore on resolve
out_count  out  CNT_W  lanes dispatched this cycle
out_src1 / out_src2  out  N*PREG_W  renamed sources
out_src1_rdy / out_src2_rdy  out  N  source ready
out_tnew / out_told  out  N*PREG_W  new/old dest mapping (tnew=told when no dest)
out_bmask  out  N*NUM_CKPT  dependence mask per lane
out_ckpt_id  out  N*CKPT_W  allocated slot (branch lanes)
ckpt_full  out  1  no free checkpoint slot

Behaviour:
- State: map[ARCH_REGS], live_bmask, ckpt_valid[NUM_CKPT], ckpt_map[NUM_CKPT][ARCH_REGS], ckpt_mask[NUM_CKPT].
- Async reset: map[i]=i; live_bmask=0; ckpt_valid=0. While in reset, out_count=0 and all outputs are 0.
- limit = min(in_count, rob_spots, rs_spots, free_count). Lanes are processed in order. Processing stops at the first branch lane when no free slot remains; the earlier lanes still dispatch. out_count is 0 whenever br_valid&&br_mispredict.
- Sources: map lookup with bypass from the youngest earlier lane in the group that writes the same rd. rd==0 is treated as no dest.
- Ready rules:
  - Unused source: ready.
  - Source bypassed from an in-group producer: not ready.
  - Otherwise ready = complete_list[tag] OR any cdb_valid&&cdb_tag match.
- Branch lane: takes the lowest free slot not already taken by an earlier lane this cycle. It stores the map including its own rename, and stores mask = live mask before its bit. Later lanes in the group carry its bit in out_bmask. The branch's own out_bmask excludes its own bit.
- All outputs are combinational from current state and inputs. map, live_bmask and ckpt state update on the next clock edge (latency 1).
- Correct resolve (br_valid, !br_mispredict):
  - Clear bit br_id in live_bmask and in every ckpt_mask; free the slot.
  - out_bmask for same-cycle dispatch already has the bit cleared.
  - A slot freed this cycle is not allocatable until the next cycle.
- Mispredict:
  - map <= ckpt_map[br_id]; live_bmask <= ckpt_mask[br_id].
  - Free br_id and every slot whose mask contains br_id.
  - Dispatch is suppressed that cycle.
- br_valid on an invalid slot: ignored.

Decomposition:
- Shared package: typedefs ARCH_REG_IDX, PHYS_REG_IDX, CKPT_MASK, CKPT_ENTRY {map, mask}; constants N, NUM_CKPT, ARCH_REGS, PHYS_REGS.
- Sub-module ckpt_alloc: priority-select up to min(N, NUM_CKPT) lowest free slots from ~ckpt_valid, returning one-hot grants.

Test Plan:
- Reset mid-operation with 2 ckpts live -> next cycle ckpt_full=0, map[5] reads 5, out_count=0 during reset.
- in_count=2, lane0 rd=x3 (tnew=40), lane1 rs1=x3 -> out_src1[1]=40, rdy=0; out_told[0]=3.
- rob_spots=1, rs_spots=2, free_count=2, in_count=2 -> out_count=1.
- 4 ckpts live, lane0 ALU, lane1 branch -> out_count=1, ckpt_full=1.
- Branch lane0 allocates slot0, lane1 rd=x7 (tnew=50); next cycle br_mispredict id0 -> map[7] restored to prior value, slot0 free, out_count=0 that cycle.
- Correct resolve of slot1 while lane0 dispatches -> out_bmask[0] bit1=0, slot1 ckpt_valid=0 next cycle, slot1 not granted this cycle.

Source files
------------

// File: rtl/rename_dispatch_ckpt_pkg.sv
// Shared types and sizing for the rename/dispatch stage with local branch checkpoints.
package rename_dispatch_ckpt_pkg;

    localparam int N         = 2;
    localparam int ARCH_REGS = 32;
    localparam int PHYS_REGS = 64;
    localparam int NUM_CKPT  = 4;
    localparam int CNT_W     = $clog2(N + 1);
    localparam int AREG_W    = $clog2(ARCH_REGS);
    localparam int PREG_W    = $clog2(PHYS_REGS);
    localparam int CKPT_W    = $clog2(NUM_CKPT);

    typedef logic [AREG_W-1:0]   ARCH_REG_IDX;
    typedef logic [PREG_W-1:0]   PHYS_REG_IDX;
    typedef logic [NUM_CKPT-1:0] CKPT_MASK;
    typedef logic [CKPT_W-1:0]   CKPT_IDX;
    typedef logic [CNT_W-1:0]    CNT_T;
    typedef PHYS_REG_IDX [ARCH_REGS-1:0] MAP_T;

    typedef struct packed {
        MAP_T     map;
        CKPT_MASK mask;
    } CKPT_ENTRY;

    function automatic CNT_T cnt_min(input CNT_T a, input CNT_T b);
        return (a < b) ? a : b;
    endfunction

    function automatic CKPT_IDX oh2idx(input CKPT_MASK oh);
        CKPT_IDX idx;
        idx = '0;
        for (int k = 0; k < NUM_CKPT; k++) begin
            if (oh[k]) idx = idx | CKPT_IDX'(k);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rename_dispatch_ckpt_if.sv
// Decoder-side and backend-side signal bundle of the rename/dispatch stage.
interface rename_dispatch_ckpt_if;
    import rename_dispatch_ckpt_pkg::*;

    logic [CNT_W-1:0]       in_count;
    logic [N-1:0]           in_has_dest;
    logic [N-1:0]           in_is_branch;
    logic [N-1:0]           in_rs1_used;
    logic [N-1:0]           in_rs2_used;
    logic [N*AREG_W-1:0]    in_rs1;
    logic [N*AREG_W-1:0]    in_rs2;
    logic [N*AREG_W-1:0]    in_rd;
    logic [CNT_W-1:0]       rob_spots;
    logic [CNT_W-1:0]       rs_spots;
    logic [CNT_W-1:0]       free_count;
    logic [N*PREG_W-1:0]    free_regs;
    logic [PHYS_REGS-1:0]   complete_list;
    logic [N-1:0]           cdb_valid;
    logic [N*PREG_W-1:0]    cdb_tag;
    logic                   br_valid;
    logic [CKPT_W-1:0]      br_id;
    logic                   br_mispredict;

    logic [CNT_W-1:0]       out_count;
    logic [N*PREG_W-1:0]    out_src1;
    logic [N*PREG_W-1:0]    out_src2;
    logic [N-1:0]           out_src1_rdy;
    logic [N-1:0]           out_src2_rdy;
    logic [N*PREG_W-1:0]    out_tnew;
    logic [N*PREG_W-1:0]    out_told;
    logic [N*NUM_CKPT-1:0]  out_bmask;
    logic [N*CKPT_W-1:0]    out_ckpt_id;
    logic                   ckpt_full;

    modport master (
        output in_count, in_has_dest, in_is_branch, in_rs1_used, in_rs2_used,
               in_rs1, in_rs2, in_rd, rob_spots, rs_spots, free_count, free_regs,
               complete_list, cdb_valid, cdb_tag, br_valid, br_id, br_mispredict,
        input  out_count, out_src1, out_src2, out_src1_rdy, out_src2_rdy,
               out_tnew, out_told, out_bmask, out_ckpt_id, ckpt_full
    );

    modport slave (
        input  in_count, in_has_dest, in_is_branch, in_rs1_used, in_rs2_used,
               in_rs1, in_rs2, in_rd, rob_spots, rs_spots, free_count, free_regs,
               complete_list, cdb_valid, cdb_tag, br_valid, br_id, br_mispredict,
        output out_count, out_src1, out_src2, out_src1_rdy, out_src2_rdy,
               out_tnew, out_told, out_bmask, out_ckpt_id, ckpt_full
    );

endinterface

// File: rtl/rename_dispatch_ckpt_alloc.sv
// Picks the lowest free checkpoint slots, one one-hot grant per potential branch lane.
// A zero grant means no slot is left for that position.
module ckpt_alloc
    import rename_dispatch_ckpt_pkg::*;
(
    input  CKPT_MASK           i_free,
    output CKPT_MASK [N-1:0]   o_grant
);

    localparam int GRANTS = (N < NUM_CKPT) ? N : NUM_CKPT;

    CKPT_MASK w_avail;

    // Peel off the lowest set bit of the remaining free set once per grant.
    always_comb begin
        w_avail = i_free;
        o_grant = '0;
        for (int k = 0; k < GRANTS; k++) begin
            o_grant[k] = w_avail & (~w_avail + CKPT_MASK'(1));
            w_avail    = w_avail & ~o_grant[k];
        end
    end

endmodule

// File: rtl/rename_dispatch_ckpt.sv
// N-wide rename/dispatch stage: map-table rename with intra-group bypass,
// branch checkpoint allocation, and restore/release on branch resolution.
module rename_dispatch_ckpt
    import rename_dispatch_ckpt_pkg::*;
(
    input  logic                    clock,
    input  logic                    reset,
    rename_dispatch_ckpt_if.slave   bus
);

    MAP_T        r_map;
    CKPT_MASK    r_live_bmask;
    CKPT_MASK    r_ckpt_valid;
    CKPT_ENTRY   r_ckpt [NUM_CKPT];

    CKPT_MASK          w_br_oh;
    logic              w_br_hit;
    logic              w_res_ok;
    logic              w_mis_ok;
    CKPT_MASK          w_live_eff;
    CKPT_MASK          w_kill;
    CNT_T              w_limit;
    CKPT_MASK [N-1:0]  w_grant;

    MAP_T              w_map_work;
    logic [ARCH_REGS-1:0] w_grp;
    CKPT_MASK          w_mask_cur;
    CKPT_MASK          w_alloc;
    CKPT_MASK          w_sel;
    CNT_T              w_nbr;
    CNT_T              w_cnt;
    logic              w_stop;
    logic              w_dest;
    ARCH_REG_IDX       w_rs1;
    ARCH_REG_IDX       w_rs2;
    ARCH_REG_IDX       w_rd;
    PHYS_REG_IDX       w_fr;
    CKPT_ENTRY         w_snap [NUM_CKPT];

    PHYS_REG_IDX [N-1:0] w_src1;
    PHYS_REG_IDX [N-1:0] w_src2;
    PHYS_REG_IDX [N-1:0] w_tnew;
    PHYS_REG_IDX [N-1:0] w_told;
    logic [N-1:0]        w_rdy1;
    logic [N-1:0]        w_rdy2;
    CKPT_MASK [N-1:0]    w_bmask;
    CKPT_IDX [N-1:0]     w_ckid;

    // A tag is ready if already marked complete or broadcast on the CDB this cycle.
    function automatic logic tag_ready(input PHYS_REG_IDX t,
                                       input logic [PHYS_REGS-1:0] cl,
                                       input logic [N-1:0] cv,
                                       input logic [N*PREG_W-1:0] ct);
        logic r;
        r = cl[t];
        for (int k = 0; k < N; k++) begin
            if (cv[k] && (ct[k*PREG_W +: PREG_W] == t)) r = 1'b1;
        end
        return r;
    endfunction

    ckpt_alloc u_alloc (
        .i_free  (~r_ckpt_valid),
        .o_grant (w_grant)
    );

    // Branch-resolution decode and the dispatch limit for this cycle.
    always_comb begin
        w_br_oh    = CKPT_MASK'(1) << bus.br_id;
        w_br_hit   = bus.br_valid && r_ckpt_valid[bus.br_id];
        w_res_ok   = w_br_hit && !bus.br_mispredict;
        w_mis_ok   = w_br_hit && bus.br_mispredict;
        w_live_eff = w_res_ok ? (r_live_bmask & ~w_br_oh) : r_live_bmask;
        w_kill     = w_br_oh;
        for (int s = 0; s < NUM_CKPT; s++) begin
            if (r_ckpt[s].mask[bus.br_id]) w_kill[s] = 1'b1;
        end
        if (bus.br_valid && bus.br_mispredict) begin
            w_limit = '0;
        end else begin
            w_limit = cnt_min(cnt_min(bus.in_count, bus.rob_spots),
                              cnt_min(bus.rs_spots, bus.free_count));
        end
    end

    // Walk the lanes in order: rename, bypass, readiness and checkpoint allocation.
    always_comb begin
        w_map_work = r_map;
        w_grp      = '0;
        w_mask_cur = w_live_eff;
        w_alloc    = '0;
        w_sel      = '0;
        w_nbr      = '0;
        w_cnt      = '0;
        w_stop     = 1'b0;
        w_dest     = 1'b0;
        w_rs1      = '0;
        w_rs2      = '0;
        w_rd       = '0;
        w_fr       = '0;
        w_src1     = '0;
        w_src2     = '0;
        w_tnew     = '0;
        w_told     = '0;
        w_rdy1     = '0;
        w_rdy2     = '0;
        w_bmask    = '0;
        w_ckid     = '0;
        for (int s = 0; s < NUM_CKPT; s++) begin
            w_snap[s] = '0;
        end
        for (int i = 0; i < N; i++) begin
            w_rs1 = bus.in_rs1[i*AREG_W +: AREG_W];
            w_rs2 = bus.in_rs2[i*AREG_W +: AREG_W];
            w_rd  = bus.in_rd[i*AREG_W +: AREG_W];
            w_fr  = bus.free_regs[i*PREG_W +: PREG_W];
            w_sel = '0;
            for (int k = 0; k < N; k++) begin
                if (w_nbr == CNT_T'(k)) w_sel = w_grant[k];
            end
            if (!w_stop && (CNT_T'(i) < w_limit)) begin
                if (bus.in_is_branch[i] && (w_sel == '0)) begin
                    // Out of checkpoints: this branch and everything younger waits.
                    w_stop = 1'b1;
                end else begin
                    w_src1[i] = w_map_work[w_rs1];
                    w_src2[i] = w_map_work[w_rs2];
                    w_rdy1[i] = !bus.in_rs1_used[i] || (!w_grp[w_rs1] &&
                                tag_ready(w_src1[i], bus.complete_list, bus.cdb_valid, bus.cdb_tag));
                    w_rdy2[i] = !bus.in_rs2_used[i] || (!w_grp[w_rs2] &&
                                tag_ready(w_src2[i], bus.complete_list, bus.cdb_valid, bus.cdb_tag));
                    w_dest    = bus.in_has_dest[i] && (w_rd != '0);
                    w_told[i] = w_map_work[w_rd];
                    w_tnew[i] = w_dest ? w_fr : w_told[i];
                    if (w_dest) begin
                        w_map_work[w_rd] = w_fr;
                        w_grp[w_rd]      = 1'b1;
                    end
                    w_bmask[i] = w_mask_cur;
                    if (bus.in_is_branch[i]) begin
                        // Snapshot includes this lane's own rename; mask excludes its own bit.
                        w_ckid[i] = oh2idx(w_sel);
                        for (int s = 0; s < NUM_CKPT; s++) begin
                            if (w_sel[s]) begin
                                w_snap[s].map  = w_map_work;
                                w_snap[s].mask = w_mask_cur;
                            end
                        end
                        w_mask_cur = w_mask_cur | w_sel;
                        w_alloc    = w_alloc | w_sel;
                        w_nbr      = w_nbr + CNT_T'(1);
                    end
                    w_cnt = CNT_T'(i + 1);
                end
            end
        end
    end

    assign bus.out_count    = reset ? '0 : w_cnt;
    assign bus.out_src1     = reset ? '0 : w_src1;
    assign bus.out_src2     = reset ? '0 : w_src2;
    assign bus.out_src1_rdy = reset ? '0 : w_rdy1;
    assign bus.out_src2_rdy = reset ? '0 : w_rdy2;
    assign bus.out_tnew     = reset ? '0 : w_tnew;
    assign bus.out_told     = reset ? '0 : w_told;
    assign bus.out_bmask    = reset ? '0 : w_bmask;
    assign bus.out_ckpt_id  = reset ? '0 : w_ckid;
    assign bus.ckpt_full    = reset ? 1'b0 : (&r_ckpt_valid);

    // Map table, live branch mask and slot occupancy: restore on mispredict, else advance.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int a = 0; a < ARCH_REGS; a++) begin
                r_map[a] <= PHYS_REG_IDX'(a);
            end
            r_live_bmask <= '0;
            r_ckpt_valid <= '0;
        end else if (w_mis_ok) begin
            r_map        <= r_ckpt[bus.br_id].map;
            r_live_bmask <= r_ckpt[bus.br_id].mask;
            r_ckpt_valid <= r_ckpt_valid & ~w_kill;
        end else begin
            r_map        <= w_map_work;
            r_live_bmask <= w_live_eff | w_alloc;
            r_ckpt_valid <= (w_res_ok ? (r_ckpt_valid & ~w_br_oh) : r_ckpt_valid) | w_alloc;
        end
    end

    // Checkpoint payload: written on allocation, resolved branch bit scrubbed from masks.
    always_ff @(posedge clock) begin
        for (int s = 0; s < NUM_CKPT; s++) begin
            if (w_alloc[s]) begin
                r_ckpt[s] <= w_snap[s];
            end else if (w_res_ok) begin
                r_ckpt[s].mask[bus.br_id] <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rename_dispatch_ckpt.sv
// Directed bench for rename_dispatch_ckpt with an expectation queue per step.
module tb_rename_dispatch_ckpt;
    import rename_dispatch_ckpt_pkg::*;

    localparam int S_CNT  = 0;
    localparam int S_SRC1 = 1;
    localparam int S_SRC2 = 2;
    localparam int S_RDY1 = 3;
    localparam int S_RDY2 = 4;
    localparam int S_TNEW = 5;
    localparam int S_TOLD = 6;
    localparam int S_BMSK = 7;
    localparam int S_CKID = 8;
    localparam int S_FULL = 9;

    typedef struct {
        int sel;
        int lane;
        int val;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    rename_dispatch_ckpt_if bus();

    rename_dispatch_ckpt dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    function automatic string nm(input int sel);
        case (sel)
            S_CNT:   return "out_count";
            S_SRC1:  return "out_src1";
            S_SRC2:  return "out_src2";
            S_RDY1:  return "out_src1_rdy";
            S_RDY2:  return "out_src2_rdy";
            S_TNEW:  return "out_tnew";
            S_TOLD:  return "out_told";
            S_BMSK:  return "out_bmask";
            S_CKID:  return "out_ckpt_id";
            default: return "ckpt_full";
        endcase
    endfunction

    function automatic logic [31:0] observe(input int sel, input int lane);
        case (sel)
            S_CNT:   return 32'(bus.out_count);
            S_SRC1:  return 32'(bus.out_src1[lane*PREG_W +: PREG_W]);
            S_SRC2:  return 32'(bus.out_src2[lane*PREG_W +: PREG_W]);
            S_RDY1:  return 32'(bus.out_src1_rdy[lane]);
            S_RDY2:  return 32'(bus.out_src2_rdy[lane]);
            S_TNEW:  return 32'(bus.out_tnew[lane*PREG_W +: PREG_W]);
            S_TOLD:  return 32'(bus.out_told[lane*PREG_W +: PREG_W]);
            S_BMSK:  return 32'(bus.out_bmask[lane*NUM_CKPT +: NUM_CKPT]);
            S_CKID:  return 32'(bus.out_ckpt_id[lane*CKPT_W +: CKPT_W]);
            default: return 32'(bus.ckpt_full);
        endcase
    endfunction

    task automatic expect_val(input int sel, input int lane, input int val);
        exp_q.push_back('{sel: sel, lane: lane, val: val});
    endtask

    task automatic compare();
        exp_t        e;
        logic [31:0] obs;
        #1;
        while (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            obs = observe(e.sel, e.lane);
            total++;
            assert (obs === 32'(e.val)) else begin
                bad++;
                $error("FAIL %s lane%0d observed=%0d expected=%0d", nm(e.sel), e.lane, obs, e.val);
            end
        end
    endtask

    task automatic idle();
        bus.in_count      = '0;
        bus.in_has_dest   = '0;
        bus.in_is_branch  = '0;
        bus.in_rs1_used   = '0;
        bus.in_rs2_used   = '0;
        bus.in_rs1        = '0;
        bus.in_rs2        = '0;
        bus.in_rd         = '0;
        bus.rob_spots     = CNT_W'(2);
        bus.rs_spots      = CNT_W'(2);
        bus.free_count    = CNT_W'(2);
        bus.free_regs     = '0;
        bus.complete_list = '1;
        bus.cdb_valid     = '0;
        bus.cdb_tag       = '0;
        bus.br_valid      = 1'b0;
        bus.br_id         = '0;
        bus.br_mispredict = 1'b0;
    endtask

    task automatic set_lane(input int i, input bit u1, input int r1, input bit u2, input int r2,
                            input bit d, input int rd, input bit br, input int fr);
        bus.in_rs1_used[i]                 = u1;
        bus.in_rs1[i*AREG_W +: AREG_W]     = AREG_W'(r1);
        bus.in_rs2_used[i]                 = u2;
        bus.in_rs2[i*AREG_W +: AREG_W]     = AREG_W'(r2);
        bus.in_has_dest[i]                 = d;
        bus.in_rd[i*AREG_W +: AREG_W]      = AREG_W'(rd);
        bus.in_is_branch[i]                = br;
        bus.free_regs[i*PREG_W +: PREG_W]  = PREG_W'(fr);
    endtask

    task automatic resolve(input int id, input bit mis);
        bus.br_valid      = 1'b1;
        bus.br_id         = CKPT_W'(id);
        bus.br_mispredict = mis;
    endtask

    initial begin
        rst = 1'b1;
        idle();

        // In reset: everything held at zero even with instructions offered.
        @(negedge clk);
        bus.in_count = CNT_W'(2);
        set_lane(0, 1, 5, 0, 0, 1, 6, 0, 33);
        expect_val(S_CNT, 0, 0);
        expect_val(S_FULL, 0, 0);
        expect_val(S_SRC1, 0, 0);
        compare();

        // Intra-group bypass, CDB and complete-list readiness.
        @(negedge clk);
        rst = 1'b0;
        idle();
        bus.in_count = CNT_W'(2);
        bus.complete_list[9]  = 1'b0;
        bus.complete_list[10] = 1'b0;
        bus.cdb_valid[0] = 1'b1;
        bus.cdb_tag[0*PREG_W +: PREG_W] = PREG_W'(9);
        set_lane(0, 1, 9, 1, 10, 1, 3, 0, 40);
        set_lane(1, 1, 3, 0, 0, 0, 4, 0, 41);
        expect_val(S_CNT, 0, 2);
        expect_val(S_SRC1, 0, 9);
        expect_val(S_RDY1, 0, 1);
        expect_val(S_SRC2, 0, 10);
        expect_val(S_RDY2, 0, 0);
        expect_val(S_TNEW, 0, 40);
        expect_val(S_TOLD, 0, 3);
        expect_val(S_SRC1, 1, 40);
        expect_val(S_RDY1, 1, 0);
        expect_val(S_RDY2, 1, 1);
        expect_val(S_TNEW, 1, 4);
        expect_val(S_TOLD, 1, 4);
        compare();

        // Capacity limit from ROB; rd=x0 is not a destination.
        @(negedge clk);
        idle();
        bus.in_count  = CNT_W'(2);
        bus.rob_spots = CNT_W'(1);
        set_lane(0, 1, 3, 0, 0, 1, 0, 0, 42);
        set_lane(1, 0, 0, 0, 0, 1, 8, 0, 43);
        expect_val(S_CNT, 0, 1);
        expect_val(S_SRC1, 0, 40);
        expect_val(S_RDY1, 0, 1);
        expect_val(S_TNEW, 0, 0);
        expect_val(S_TOLD, 0, 0);
        compare();

        // Branch on lane0 takes slot0; lane1 renames x7 under it.
        @(negedge clk);
        idle();
        bus.in_count = CNT_W'(2);
        set_lane(0, 0, 0, 0, 0, 0, 0, 1, 0);
        set_lane(1, 0, 0, 0, 0, 1, 7, 0, 50);
        expect_val(S_CNT, 0, 2);
        expect_val(S_CKID, 0, 0);
        expect_val(S_BMSK, 0, 0);
        expect_val(S_BMSK, 1, 1);
        expect_val(S_TNEW, 1, 50);
        expect_val(S_TOLD, 1, 7);
        expect_val(S_FULL, 0, 0);
        compare();

        @(negedge clk);
        idle();
        bus.in_count = CNT_W'(1);
        set_lane(0, 1, 7, 0, 0, 0, 0, 0, 0);
        expect_val(S_CNT, 0, 1);
        expect_val(S_SRC1, 0, 50);
        expect_val(S_BMSK, 0, 1);
        compare();

        // Mispredict slot0: dispatch suppressed this cycle.
        @(negedge clk);
        idle();
        bus.in_count = CNT_W'(1);
        set_lane(0, 1, 7, 0, 0, 0, 0, 0, 0);
        resolve(0, 1);
        expect_val(S_CNT, 0, 0);
        compare();

        // Map restored, slot0 free again.
        @(negedge clk);
        idle();
        bus.in_count = CNT_W'(2);
        set_lane(0, 1, 7, 0, 0, 0, 0, 0, 0);
        set_lane(1, 0, 0, 0, 0, 0, 0, 1, 0);
        expect_val(S_CNT, 0, 2);
        expect_val(S_SRC1, 0, 7);
        expect_val(S_BMSK, 0, 0);
        expect_val(S_CKID, 1, 0);
        expect_val(S_BMSK, 1, 0);
        expect_val(S_FULL, 0, 0);
        compare();

        // Two branches in one group take slots 1 and 2.
        @(negedge clk);
        idle();
        bus.in_count = CNT_W'(2);
        set_lane(0, 0, 0, 0, 0, 0, 0, 1, 0);
        set_lane(1, 0, 0, 0, 0, 0, 0, 1, 0);
        expect_val(S_CNT, 0, 2);
        expect_val(S_CKID, 0, 1);
        expect_val(S_CKID, 1, 2);
        expect_val(S_BMSK, 0, 1);
        expect_val(S_BMSK, 1, 3);
        compare();

        // Correct resolve of slot1 alongside dispatch: bit already clear, slot1 not regranted.
        @(negedge clk);
        idle();
        bus.in_count = CNT_W'(2);
        set_lane(1, 0, 0, 0, 0, 0, 0, 1, 0);
        resolve(1, 0);
        expect_val(S_CNT, 0, 2);
        expect_val(S_BMSK, 0, 5);
        expect_val(S_CKID, 1, 3);
        expect_val(S_BMSK, 1, 5);
        expect_val(S_FULL, 0, 0);
        compare();

        // Slot1 is free from the next cycle.
        @(negedge clk);
        idle();
        bus.in_count = CNT_W'(2);
        set_lane(0, 0, 0, 0, 0, 0, 0, 1, 0);
        expect_val(S_FULL, 0, 0);
        expect_val(S_CNT, 0, 2);
        expect_val(S_CKID, 0, 1);
        expect_val(S_BMSK, 0, 13);
        expect_val(S_BMSK, 1, 15);
        compare();

        // All four slots live: branch on lane1 stalls, lane0 still goes.
        @(negedge clk);
        idle();
        bus.in_count = CNT_W'(2);
        set_lane(1, 0, 0, 0, 0, 0, 0, 1, 0);
        expect_val(S_CNT, 0, 1);
        expect_val(S_FULL, 0, 1);
        expect_val(S_BMSK, 0, 15);
        compare();

        // Mispredict slot2 squashes younger slots 1 and 3.
        @(negedge clk);
        idle();
        bus.in_count = CNT_W'(2);
        resolve(2, 1);
        expect_val(S_CNT, 0, 0);
        compare();

        @(negedge clk);
        idle();
        bus.in_count = CNT_W'(2);
        set_lane(0, 1, 3, 1, 7, 0, 0, 0, 0);
        set_lane(1, 0, 0, 0, 0, 0, 0, 1, 0);
        expect_val(S_CNT, 0, 2);
        expect_val(S_SRC1, 0, 40);
        expect_val(S_SRC2, 0, 7);
        expect_val(S_BMSK, 0, 1);
        expect_val(S_CKID, 1, 1);
        expect_val(S_BMSK, 1, 1);
        expect_val(S_FULL, 0, 0);
        compare();

        // Resolutions naming free slots change nothing.
        @(negedge clk);
        idle();
        bus.in_count = CNT_W'(1);
        resolve(3, 0);
        expect_val(S_CNT, 0, 1);
        expect_val(S_BMSK, 0, 3);
        compare();

        @(negedge clk);
        idle();
        bus.in_count = CNT_W'(1);
        resolve(2, 1);
        expect_val(S_CNT, 0, 0);
        compare();

        @(negedge clk);
        idle();
        bus.in_count = CNT_W'(1);
        set_lane(0, 1, 3, 0, 0, 0, 0, 0, 0);
        expect_val(S_CNT, 0, 1);
        expect_val(S_BMSK, 0, 3);
        expect_val(S_SRC1, 0, 40);
        compare();

        // Reset mid-operation with two checkpoints live.
        @(negedge clk);
        rst = 1'b1;
        idle();
        bus.in_count = CNT_W'(2);
        set_lane(0, 1, 5, 0, 0, 0, 0, 0, 0);
        set_lane(1, 0, 0, 0, 0, 0, 0, 1, 0);
        expect_val(S_CNT, 0, 0);
        expect_val(S_FULL, 0, 0);
        expect_val(S_SRC1, 0, 0);
        expect_val(S_BMSK, 1, 0);
        compare();

        @(negedge clk);
        rst = 1'b0;
        idle();
        bus.in_count = CNT_W'(2);
        set_lane(0, 1, 5, 1, 3, 0, 0, 0, 0);
        set_lane(1, 0, 0, 0, 0, 0, 0, 1, 0);
        expect_val(S_CNT, 0, 2);
        expect_val(S_SRC1, 0, 5);
        expect_val(S_SRC2, 0, 3);
        expect_val(S_BMSK, 0, 0);
        expect_val(S_CKID, 1, 0);
        expect_val(S_FULL, 0, 0);
        compare();

        @(negedge clk);
        idle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
